// File: rtl/tt_bist_pkg.sv
// rtl/tt_bist_pkg.sv - shared state type and LFSR/MISR step functions
package tt_bist_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RESET,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } bist_state_e;

  localparam int STEP_W = 16;

  // Galois step on the low w bits of a 16-bit container; bits above w are cleared.
  function automatic logic [STEP_W-1:0] lfsr_next(input logic [STEP_W-1:0] v,
                                                  input logic [STEP_W-1:0] poly,
                                                  input int                w);
    logic [STEP_W-1:0] mask;
    mask = 16'hFFFF >> (STEP_W - w);
    return ({v[STEP_W-2:0], 1'b0} ^ (v[4'(w - 1)] ? poly : '0)) & mask;
  endfunction

  function automatic logic [STEP_W-1:0] misr_next(input logic [STEP_W-1:0] v,
                                                  input logic [STEP_W-1:0] poly,
                                                  input int                w,
                                                  input logic [STEP_W-1:0] din);
    return lfsr_next(v, poly, w) ^ din;
  endfunction

endpackage

// File: rtl/tt_lfsr_step.sv
// rtl/tt_lfsr_step.sv - loadable shift register stepping as LFSR (shift_in=0) or MISR
module tt_lfsr_step
  import tt_bist_pkg::*;
#(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] POLY  = WIDTH'(8'h1D)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_val,
  input  logic             i_en,
  input  logic [WIDTH-1:0] i_shift_in,
  output logic [WIDTH-1:0] o_value
);

  logic [WIDTH-1:0] r_val;
  logic [WIDTH-1:0] w_step;

  assign w_step = WIDTH'(misr_next(STEP_W'(r_val), STEP_W'(POLY), WIDTH, STEP_W'(i_shift_in)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_val <= '0;
    end else if (i_load) begin
      r_val <= i_load_val;
    end else if (i_en) begin
      r_val <= w_step;
    end
  end

  assign o_value = r_val;

endmodule

// File: rtl/tt_bist_harness.sv
// rtl/tt_bist_harness.sv - LFSR stimulus / MISR response BIST sequencer with DUT reset control
module tt_bist_harness
  import tt_bist_pkg::*;
#(
  parameter int               WIDTH      = 8,
  parameter int               CYCLES     = 256,
  parameter int               SETTLE     = 1,
  parameter int               RST_CYCLES = 4,
  parameter logic [WIDTH-1:0] POLY       = WIDTH'(8'h1D),
  parameter logic [WIDTH-1:0] SEED       = WIDTH'(1),
  parameter logic [WIDTH-1:0] GOLDEN     = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             start,
  input  logic             abort,
  output logic [WIDTH-1:0] stim_out,
  input  logic [WIDTH-1:0] resp_in,
  output logic             dut_rst_n,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [WIDTH-1:0] signature
);

  localparam logic [WIDTH-1:0] SEED_EFF   = (SEED == '0) ? WIDTH'(1) : SEED;
  localparam logic [15:0]      LAST_RUN   = 16'(CYCLES - 1);
  localparam logic [15:0]      SETTLE_16  = 16'(SETTLE);
  localparam logic [3:0]       LAST_RST   = 4'(RST_CYCLES - 1);
  localparam logic [3:0]       LAST_DRAIN = 4'(SETTLE - 1);

  bist_state_e      r_state, w_state_d;
  logic [15:0]      r_cnt, w_cnt_d;
  logic [3:0]       r_sub, w_sub_d;
  logic             r_start_d, r_rel, r_pass;
  logic             w_launch, w_lfsr_en, w_misr_en;
  logic [WIDTH-1:0] w_lfsr, w_misr, w_sig_d;

  always_comb begin
    w_state_d = r_state;
    w_cnt_d   = r_cnt;
    w_sub_d   = r_sub;
    w_launch  = 1'b0;
    w_lfsr_en = 1'b0;
    w_misr_en = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start && !r_start_d) begin
          w_state_d = ST_RESET;
          w_cnt_d   = '0;
          w_sub_d   = '0;
          w_launch  = 1'b1;
        end
      end
      ST_RESET: begin
        if (r_sub == LAST_RST) begin
          w_state_d = ST_RUN;
          w_sub_d   = '0;
        end else begin
          w_sub_d = r_sub + 4'd1;
        end
      end
      ST_RUN: begin
        // The LFSR stays put on the final RUN cycle so DRAIN keeps presenting that vector.
        w_lfsr_en = (r_cnt != LAST_RUN);
        w_misr_en = (r_cnt >= SETTLE_16);
        if (r_cnt == LAST_RUN) begin
          w_state_d = (SETTLE == 0) ? ST_DONE : ST_DRAIN;
          w_sub_d   = '0;
        end else begin
          w_cnt_d = r_cnt + 16'd1;
        end
      end
      ST_DRAIN: begin
        w_misr_en = 1'b1;
        if (r_sub == LAST_DRAIN) begin
          w_state_d = ST_DONE;
          w_sub_d   = '0;
        end else begin
          w_sub_d = r_sub + 4'd1;
        end
      end
      ST_DONE: begin
        if (!start) w_state_d = ST_IDLE;
      end
      default: w_state_d = ST_IDLE;
    endcase
    if (abort) begin
      w_state_d = ST_IDLE;
      w_launch  = 1'b0;
      w_lfsr_en = 1'b0;
      w_misr_en = 1'b0;
    end
  end

  assign w_sig_d = w_misr_en
                 ? WIDTH'(misr_next(STEP_W'(w_misr), STEP_W'(POLY), WIDTH, STEP_W'(resp_in)))
                 : w_misr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_sub     <= '0;
      r_start_d <= 1'b0;
      r_pass    <= 1'b0;
      r_rel     <= 1'b0;
    end else begin
      r_rel <= 1'b1;
      if (ena) begin
        r_state   <= w_state_d;
        r_cnt     <= w_cnt_d;
        r_sub     <= w_sub_d;
        r_start_d <= start;
        r_pass    <= (w_state_d == ST_DONE) && (w_sig_d == GOLDEN);
      end
    end
  end

  tt_lfsr_step #(.WIDTH(WIDTH), .POLY(POLY)) u_lfsr (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (ena & w_launch),
    .i_load_val (SEED_EFF),
    .i_en       (ena & w_lfsr_en),
    .i_shift_in ({WIDTH{1'b0}}),
    .o_value    (w_lfsr)
  );

  tt_lfsr_step #(.WIDTH(WIDTH), .POLY(POLY)) u_misr (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (ena & w_launch),
    .i_load_val ({WIDTH{1'b0}}),
    .i_en       (ena & w_misr_en),
    .i_shift_in (resp_in),
    .o_value    (w_misr)
  );

  assign stim_out  = (r_state == ST_RUN || r_state == ST_DRAIN) ? w_lfsr : '0;
  assign dut_rst_n = r_rel && (r_state != ST_RESET);
  assign busy      = (r_state == ST_RESET) || (r_state == ST_RUN) || (r_state == ST_DRAIN);
  assign done      = (r_state == ST_DONE);
  assign pass      = r_pass;
  assign signature = w_misr;

endmodule

// File: doc/tt_bist_harness.md
TT_BIST_HARNESS -- requirements
Module: tt_bist_harness

Interface
REQ-001 SHALL have parameter WIDTH, default 8, stimulus/response width in bits (4..16).
REQ-002 SHALL have parameter CYCLES, default 256, number of response samples compacted per run (1..65535).
REQ-003 SHALL have parameter SETTLE, default 1, DUT response latency in clocks (0..15).
REQ-004 SHALL have parameter RST_CYCLES, default 4, DUT reset pulse length in clocks (1..15).
REQ-005 SHALL have parameter POLY, default 8'h1D (WIDTH bits), feedback polynomial shared by LFSR and MISR.
REQ-006 SHALL have parameter SEED, default 1, LFSR start value; zero SHALL be replaced by 1.
REQ-007 SHALL have parameter GOLDEN, default 0, expected final signature.
REQ-008 clk  input  1  sole clock; all state on rising edge.
REQ-009 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-010 ena  input  1  design enable; low freezes all state.
REQ-011 start  input  1  level; rising edge (sampled) launches a run.
REQ-012 abort  input  1  forces return to IDLE.
REQ-013 stim_out  output  WIDTH  stimulus to DUT inputs.
REQ-014 resp_in  input  WIDTH  DUT outputs to compact.
REQ-015 dut_rst_n  output  1  active-low reset to DUT.
REQ-016 busy  output  1  high in RESET, RUN, DRAIN.
REQ-017 done  output  1  high in DONE.
REQ-018 pass  output  1  valid while done; signature == GOLDEN.
REQ-019 signature  output  WIDTH  current MISR value.

Function
REQ-020 States SHALL be IDLE, RESET, RUN, DRAIN, DONE; one transition per enabled clock at most.
REQ-021 IDLE -> RESET on start rising edge; LFSR loads SEED, MISR loads 0, counters clear.
REQ-022 RESET: dut_rst_n=0 for exactly RST_CYCLES clocks, then -> RUN; dut_rst_n=1 in all other states.
REQ-023 RUN: stim_out = LFSR; LFSR next = {lfsr[W-2:0],0} XOR (lfsr[W-1] ? POLY : 0), advancing every RUN cycle.
REQ-024 MISR next = ({misr[W-2:0],0} XOR (misr[W-1] ? POLY : 0)) XOR resp_in; updates only on compaction cycles.
REQ-025 Compaction cycles: RUN cycles with index >= SETTLE plus all DRAIN cycles; total exactly CYCLES.
REQ-026 RUN lasts CYCLES clocks, then -> DRAIN for SETTLE clocks (skipped if SETTLE=0), then -> DONE.
REQ-027 DRAIN holds stim_out at last RUN value; LFSR frozen.
REQ-028 DONE: pass = (signature == GOLDEN), registered; hold until start low, then -> IDLE.
REQ-029 start held high through DONE SHALL NOT relaunch; a new rising edge is required.
REQ-030 abort high in any state -> IDLE next clock; abort wins over simultaneous start edge.
REQ-031 ena low: state, counters, LFSR, MISR, outputs held; start edge detector also held.
REQ-032 stim_out SHALL be 0 in IDLE and RESET.

Reset
REQ-033 On rst_n low: state=IDLE, stim_out=0, dut_rst_n=0, busy=0, done=0, pass=0, signature=0, counters=0.
REQ-034 dut_rst_n SHALL follow rst_n asynchronously low and return high on first clock after release.
REQ-035 Reset mid-run SHALL discard the run; no partial done/pass.

Structure
REQ-036 Shared package tt_bist_pkg SHALL hold state enum and next-value functions for LFSR/MISR step.
REQ-037 One sub-module tt_lfsr_step (WIDTH, POLY, load, en, shift_in) SHALL be instantiated twice: LFSR (shift_in=0) and MISR (shift_in=resp_in).
REQ-038 Cycle counter width SHALL be 16 bits; settle/reset counter 4 bits.

Verification
REQ-039 WIDTH=8, POLY=1D, SEED=01: stim_out in RUN = 01,02,04,08,10,20,40,80,1D,3A.
REQ-040 SEED=0 -> first RUN stim_out = 01.
REQ-041 Loopback resp_in=stim_out, SETTLE=0, CYCLES=16: signature matches bench model; GOLDEN=model -> pass=1, GOLDEN=model^1 -> pass=0.
REQ-042 start edge -> dut_rst_n low exactly 4 clocks, busy high, done after 4+CYCLES+SETTLE clocks.
REQ-043 abort in RUN cycle 5 -> IDLE next clock, busy=0, done=0; new start edge reruns identically.
REQ-044 ena low 10 clocks mid-RUN -> final signature identical to uninterrupted run.
